// File: rtl/reg_wb_arbiter_if.sv
// Bus bundle between the ALU/LSU write-back paths, the register file write
// port and decode's hazard query. The arbiter uses the slave view and the
// surrounding pipeline uses the master view.
interface reg_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            rdy_in;
    logic            stall;

    logic            alu_req;
    logic [REGW-1:0] alu_rd;
    logic [XLEN-1:0] alu_val;
    logic            alu_ack;

    logic            lsu_req;
    logic [REGW-1:0] lsu_rd;
    logic [XLEN-1:0] lsu_val;
    logic            lsu_ack;

    logic [REGW-1:0] rf_rd;
    logic [XLEN-1:0] rf_write_val;
    logic            rf_write_rdy;
    logic            rf_write_fin;

    logic [REGW-1:0] rs1_q;
    logic [REGW-1:0] rs2_q;
    logic            hazard_rs1;
    logic            hazard_rs2;

    logic            busy;

    modport slave (
        input  rdy_in, stall,
        input  alu_req, alu_rd, alu_val,
        input  lsu_req, lsu_rd, lsu_val,
        input  rf_write_fin,
        input  rs1_q, rs2_q,
        output alu_ack, lsu_ack,
        output rf_rd, rf_write_val, rf_write_rdy,
        output hazard_rs1, hazard_rs2,
        output busy
    );

    modport master (
        output rdy_in, stall,
        output alu_req, alu_rd, alu_val,
        output lsu_req, lsu_rd, lsu_val,
        output rf_write_fin,
        output rs1_q, rs2_q,
        input  alu_ack, lsu_ack,
        input  rf_rd, rf_write_val, rf_write_rdy,
        input  hazard_rs1, hazard_rs2,
        input  busy
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port. Grants the
// ALU or LSU write-back request, drives the regFile write_rdy/write_fin
// handshake, acks the winner for one cycle, and flags RAW hazards to decode.
module reg_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic              clk_in,
    input  logic              rst_n,
    reg_wb_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state_reg, state_next;

    // 1 = LSU was granted last (so ALU wins a tie next), 0 = ALU last.
    logic            last_reg, last_next;
    // Owner of the latched write: 1 = LSU, 0 = ALU.
    logic            win_reg, win_next;

    logic [REGW-1:0] rf_rd_reg, rf_rd_next;
    logic [XLEN-1:0] wval_reg, wval_next;
    logic            wrdy_reg, wrdy_next;
    logic            alu_ack_reg, alu_ack_next;
    logic            lsu_ack_reg, lsu_ack_next;
    logic            busy_reg, busy_next;

    logic            pick_lsu;
    logic            grant;
    logic [REGW-1:0] grant_rd;
    logic [XLEN-1:0] grant_val;

    // Grant decision: single requester wins outright, a tie goes to the one
    // not granted last. Grants only happen from IDLE, so the retiring
    // requester cannot be re-granted during its ACK cycle.
    always_comb begin
        pick_lsu  = bus.lsu_req & (~bus.alu_req | ~last_reg);
        grant     = (state_reg == IDLE) & ~bus.stall & (bus.alu_req | bus.lsu_req);
        grant_rd  = pick_lsu ? bus.lsu_rd  : bus.alu_rd;
        grant_val = pick_lsu ? bus.lsu_val : bus.alu_val;
    end

    // State and registered outputs; rdy_in low freezes everything, so an
    // rf_write_fin seen while frozen is simply not captured.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            last_reg    <= 1'b1;
            win_reg     <= 1'b0;
            rf_rd_reg   <= '0;
            wval_reg    <= '0;
            wrdy_reg    <= 1'b0;
            alu_ack_reg <= 1'b0;
            lsu_ack_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else if (bus.rdy_in) begin
            state_reg   <= state_next;
            last_reg    <= last_next;
            win_reg     <= win_next;
            rf_rd_reg   <= rf_rd_next;
            wval_reg    <= wval_next;
            wrdy_reg    <= wrdy_next;
            alu_ack_reg <= alu_ack_next;
            lsu_ack_reg <= lsu_ack_next;
            busy_reg    <= busy_next;
        end
    end

    // Next-state: writes to x0 skip the regFile handshake and go straight to ACK.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant) begin
                    state_next = (grant_rd == '0) ? ACK : WRITE;
                end
            end
            WRITE: begin
                if (bus.rf_write_fin) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state so the
    // outputs come straight from flops.
    always_comb begin
        last_next  = last_reg;
        win_next   = win_reg;
        rf_rd_next = rf_rd_reg;
        wval_next  = wval_reg;
        if (grant) begin
            last_next  = pick_lsu;
            win_next   = pick_lsu;
            rf_rd_next = grant_rd;
            wval_next  = grant_val;
        end
        wrdy_next    = (state_next == WRITE);
        alu_ack_next = (state_next == ACK) & ~win_next;
        lsu_ack_next = (state_next == ACK) &  win_next;
        busy_next    = (state_next != IDLE);
    end

    assign bus.rf_rd        = rf_rd_reg;
    assign bus.rf_write_val = wval_reg;
    assign bus.rf_write_rdy = wrdy_reg;
    assign bus.alu_ack      = alu_ack_reg;
    assign bus.lsu_ack      = lsu_ack_reg;
    assign bus.busy         = busy_reg;

    // Hazard lookup, one comparator set per decode source port.
    logic [REGW-1:0] rs_q [2];
    logic            hazard [2];

    assign rs_q[0] = bus.rs1_q;
    assign rs_q[1] = bus.rs2_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
            // x0 never carries a hazard; otherwise match any pending or in-flight rd.
            always_comb begin
                hazard[gi] = (rs_q[gi] != '0) &
                             ((bus.alu_req & (rs_q[gi] == bus.alu_rd)) |
                              (bus.lsu_req & (rs_q[gi] == bus.lsu_rd)) |
                              ((state_reg == WRITE) & (rs_q[gi] == rf_rd_reg)));
            end
        end
    endgenerate

    assign bus.hazard_rs1 = hazard[0];
    assign bus.hazard_rs2 = hazard[1];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: grant/retire timing, round-robin order,
// x0 writes, hazards, stall, rdy_in freeze and reset in the middle of a write.
module tb_reg_wb_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    reg_wb_arbiter_if #(.XLEN(32), .REGW(5)) bus ();

    reg_wb_arbiter #(.XLEN(32), .REGW(5)) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.rdy_in = 1'b1;
        bus.stall = 1'b0;
        bus.alu_req = 1'b0;
        bus.alu_rd = '0;
        bus.alu_val = '0;
        bus.lsu_req = 1'b0;
        bus.lsu_rd = '0;
        bus.lsu_val = '0;
        bus.rf_write_fin = 1'b0;
        bus.rs1_q = '0;
        bus.rs2_q = '0;
        step();
        step();

        // Reset state
        check("rst_wrdy", 32'(bus.rf_write_rdy), 32'd0);
        check("rst_rd",   32'(bus.rf_rd), 32'd0);
        check("rst_val",  bus.rf_write_val, 32'd0);
        check("rst_aack", 32'(bus.alu_ack), 32'd0);
        check("rst_lack", 32'(bus.lsu_ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic ALU write, fin two cycles into WRITE
        bus.alu_req = 1'b1; bus.alu_rd = 5'd5; bus.alu_val = 32'hDEADBEEF;
        step();
        check("t1_wrdy", 32'(bus.rf_write_rdy), 32'd1);
        check("t1_rd",   32'(bus.rf_rd), 32'd5);
        check("t1_val",  bus.rf_write_val, 32'hDEADBEEF);
        check("t1_busy", 32'(bus.busy), 32'd1);
        step();
        check("t1_wait", 32'(bus.rf_write_rdy), 32'd1);
        bus.rf_write_fin = 1'b1;
        step();
        check("t1_ack_wrdy", 32'(bus.rf_write_rdy), 32'd0);
        check("t1_aack", 32'(bus.alu_ack), 32'd1);
        check("t1_lack", 32'(bus.lsu_ack), 32'd0);
        bus.rf_write_fin = 1'b0; bus.alu_req = 1'b0;
        $display("write alu rd=5 val=deadbeef");
        step();
        check("t1_aack_end", 32'(bus.alu_ack), 32'd0);
        check("t1_idle", 32'(bus.busy), 32'd0);

        // Reset so the round-robin run starts with ALU priority
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Both held: ALU, LSU, ALU, LSU with ACK + IDLE between writes
        bus.alu_req = 1'b1; bus.alu_rd = 5'd3; bus.alu_val = 32'h11110003;
        bus.lsu_req = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_val = 32'h22220004;
        for (int i = 0; i < 4; i++) begin
            logic exp_lsu;
            exp_lsu = (i % 2) == 1;
            step();
            check("rr_wrdy", 32'(bus.rf_write_rdy), 32'd1);
            check("rr_rd", 32'(bus.rf_rd), exp_lsu ? 32'd4 : 32'd3);
            check("rr_val", bus.rf_write_val, exp_lsu ? 32'h22220004 : 32'h11110003);
            bus.rf_write_fin = 1'b1;
            step();
            check("rr_aack", 32'(bus.alu_ack), exp_lsu ? 32'd0 : 32'd1);
            check("rr_lack", 32'(bus.lsu_ack), exp_lsu ? 32'd1 : 32'd0);
            bus.rf_write_fin = 1'b0;
            $display("write %s rd=%0d", exp_lsu ? "lsu" : "alu", exp_lsu ? 4 : 3);
            step();
            check("rr_idle", 32'(bus.busy), 32'd0);
        end
        bus.alu_req = 1'b0; bus.lsu_req = 1'b0;
        step();

        // LSU write to x0: no write_rdy, ack one cycle after the request
        bus.lsu_req = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_val = 32'h12345678;
        step();
        check("x0_wrdy", 32'(bus.rf_write_rdy), 32'd0);
        check("x0_lack", 32'(bus.lsu_ack), 32'd1);
        check("x0_busy", 32'(bus.busy), 32'd1);
        bus.lsu_req = 1'b0;
        $display("write lsu rd=0 (x0)");
        step();
        check("x0_lack_end", 32'(bus.lsu_ack), 32'd0);
        check("x0_wrdy_end", 32'(bus.rf_write_rdy), 32'd0);

        // fin while IDLE is ignored
        bus.rf_write_fin = 1'b1;
        step();
        check("fin_idle_busy", 32'(bus.busy), 32'd0);
        check("fin_idle_ack", 32'(bus.alu_ack), 32'd0);
        bus.rf_write_fin = 1'b0;

        // Hazards: ALU rd=7 pending (held back by stall)
        bus.stall = 1'b1;
        bus.alu_req = 1'b1; bus.alu_rd = 5'd7; bus.alu_val = 32'h7;
        bus.rs1_q = 5'd7; bus.rs2_q = 5'd0;
        #1;
        check("hz_rs1_pend", 32'(bus.hazard_rs1), 32'd1);
        check("hz_rs2_x0", 32'(bus.hazard_rs2), 32'd0);
        step();
        check("stall_nogrant", 32'(bus.rf_write_rdy), 32'd0);
        check("stall_busy", 32'(bus.busy), 32'd0);
        bus.stall = 1'b0;
        step();
        check("unstall_grant", 32'(bus.rf_write_rdy), 32'd1);
        check("hz_rs1_write", 32'(bus.hazard_rs1), 32'd1);
        // Stall mid-WRITE, and a fin during rdy_in=0 must not be captured
        bus.stall = 1'b1;
        bus.rdy_in = 1'b0; bus.rf_write_fin = 1'b1;
        step();
        check("frz_wrdy", 32'(bus.rf_write_rdy), 32'd1);
        check("frz_aack", 32'(bus.alu_ack), 32'd0);
        bus.rdy_in = 1'b1; bus.rf_write_fin = 1'b0;
        step();
        check("frz_nofin", 32'(bus.rf_write_rdy), 32'd1);
        bus.rf_write_fin = 1'b1;
        step();
        check("stall_ack", 32'(bus.alu_ack), 32'd1);
        bus.rf_write_fin = 1'b0; bus.alu_req = 1'b0; bus.stall = 1'b0;
        #1;
        check("hz_rs1_clear", 32'(bus.hazard_rs1), 32'd0);
        $display("write alu rd=7 val=7");
        step();

        // Reset mid-WRITE: last=ALU so LSU wins first, reset abandons it
        bus.alu_req = 1'b1; bus.alu_rd = 5'd10; bus.alu_val = 32'hA;
        bus.lsu_req = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_val = 32'hB;
        bus.rs1_q = 5'd0;
        step();
        check("mr_rd", 32'(bus.rf_rd), 32'd11);
        check("mr_wrdy", 32'(bus.rf_write_rdy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mr_wrdy_rst", 32'(bus.rf_write_rdy), 32'd0);
        check("mr_lack_rst", 32'(bus.lsu_ack), 32'd0);
        check("mr_busy_rst", 32'(bus.busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("mr_regrant_rd", 32'(bus.rf_rd), 32'd10);
        check("mr_regrant_wrdy", 32'(bus.rf_write_rdy), 32'd1);
        bus.rf_write_fin = 1'b1;
        step();
        check("mr_aack", 32'(bus.alu_ack), 32'd1);
        check("mr_lack", 32'(bus.lsu_ack), 32'd0);
        bus.rf_write_fin = 1'b0; bus.alu_req = 1'b0;
        $display("write alu rd=10 val=a");
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
